// File: rtl/ecc_core_wpack_if.sv
// ecc_core_wpack_if
//   Bundles the byte-side inputs and the word-write outputs of the ECC core
//   byte-to-word packer.
//   master : upstream/system side (drives frame control and bytes)
//   slave  : packer side (drives word writes and status)
//   Signals:
//     load_rcv, wr_size          frame start and frame length in bytes
//     byte_vld, byte_data        incoming byte strobe and data
//     wr_en, wr_data, wr_addr    one-cycle word write toward the ECC buffer
//     busy, pack_done, ovf_err   frame status
interface ecc_core_wpack_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              load_rcv;
    logic [15:0]       wr_size;
    logic              byte_vld;
    logic [7:0]        byte_data;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              busy;
    logic              pack_done;
    logic              ovf_err;

    modport master (
        output load_rcv, wr_size, byte_vld, byte_data,
        input  wr_en, wr_data, wr_addr, busy, pack_done, ovf_err
    );

    modport slave (
        input  load_rcv, wr_size, byte_vld, byte_data,
        output wr_en, wr_data, wr_addr, busy, pack_done, ovf_err
    );
endinterface

// File: rtl/ecc_core_wpack.sv
// ecc_core_wpack
//   Packs the SPI byte stream into 32-bit little-endian words for the ECC
//   core input buffer. The frame length is latched at load_rcv; a final
//   partial word is zero-padded and flushed, so exactly ceil(wr_size/4)
//   word writes are issued per frame.
//   Ports:
//     clk  system clock, rising edge
//     rst  asynchronous active-high reset
//     bus  ecc_core_wpack_if slave modport (frame control, bytes in,
//          word writes and status out); all outputs are registered
module ecc_core_wpack #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ecc_core_wpack_if.slave       bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    logic [0:0]        state_q;
    logic [15:0]       rem_q;
    logic [1:0]        lane_q;
    logic [31:0]       acc_q;
    logic              wr_en_q;
    logic [31:0]       wr_data_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              pack_done_q;
    logic              ovf_err_q;

    logic [31:0]       lane_byte;
    logic [31:0]       merged;
    logic              last_byte;
    logic              word_full;

    // Current byte placed in its lane and merged with the bytes so far.
    always_comb begin
        lane_byte = {24'd0, bus.byte_data} << {lane_q, 3'b000};
        merged    = acc_q | lane_byte;
        last_byte = (rem_q == 16'd1);
        word_full = (lane_q == 2'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            lane_q      <= '0;
            acc_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            pack_done_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            pack_done_q <= 1'b0;

            // Address advances after each write; a frame start overrides it.
            if (wr_en_q) begin
                wr_addr_q <= wr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end

            if (bus.load_rcv) begin
                // Frame start wins over any coincident byte (discarded, no ovf).
                wr_addr_q <= '0;
                ovf_err_q <= 1'b0;
                lane_q    <= '0;
                acc_q     <= '0;
                if (bus.wr_size != 16'd0) begin
                    state_q <= ST_RECV;
                    rem_q   <= bus.wr_size;
                end else begin
                    state_q     <= ST_IDLE;
                    rem_q       <= '0;
                    pack_done_q <= 1'b1;
                end
            end else if (bus.byte_vld) begin
                if (state_q == ST_IDLE) begin
                    ovf_err_q <= 1'b1;
                end else begin
                    rem_q  <= rem_q - 16'd1;
                    lane_q <= lane_q + 2'd1;
                    if (word_full || last_byte) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= merged;
                        acc_q     <= '0;
                    end else begin
                        acc_q <= merged;
                    end
                    if (last_byte) begin
                        state_q     <= ST_IDLE;
                        pack_done_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.busy      = (state_q == ST_RECV);
    assign bus.pack_done = pack_done_q;
    assign bus.ovf_err   = ovf_err_q;
endmodule

// File: tb/tb_ecc_core_wpack.sv
// tb_ecc_core_wpack
//   Directed self-checking bench for ecc_core_wpack. A negedge monitor logs
//   every word write (data, address, pack_done, busy); each test task drives
//   its scenario and compares the log and live outputs against hand-computed
//   values.
module tb_ecc_core_wpack;
    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  a;
        logic        pd;
        logic        busy;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   pd_cnt = 0;
    logic busy_seen = 1'b0;
    wr_t  wq[$];

    ecc_core_wpack_if #(.ADDR_W(8)) bus ();

    ecc_core_wpack #(.ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_en) wq.push_back('{d: bus.wr_data, a: bus.wr_addr, pd: bus.pack_done, busy: bus.busy});
        if (bus.pack_done) pd_cnt++;
        if (bus.busy) busy_seen = 1'b1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clear_log();
        wq.delete();
        pd_cnt    = 0;
        busy_seen = 1'b0;
    endtask

    task automatic load(input logic [15:0] n);
        bus.load_rcv = 1'b1;
        bus.wr_size  = n;
        cyc();
        bus.load_rcv = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        bus.byte_vld  = 1'b1;
        bus.byte_data = b;
        cyc();
        bus.byte_vld  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({bus.wr_en, bus.wr_data, bus.wr_addr, bus.busy, bus.pack_done, bus.ovf_err} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b data=%h addr=%h busy=%b pd=%b ovf=%b want all 0",
                     bus.wr_en, bus.wr_data, bus.wr_addr, bus.busy, bus.pack_done, bus.ovf_err);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_multiple4();
        clear_log();
        load(16'd8);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL m4_busy_start got %b want 1", bus.busy); end
        for (int i = 1; i <= 4; i++) put(8'(i));
        checks++;
        if (bus.wr_en !== 1'b1 || bus.wr_data !== 32'h04030201 || bus.wr_addr !== 8'd0) begin
            errors++;
            $display("FAIL m4_word0_timing got en=%b data=%h addr=%h want 1 04030201 00", bus.wr_en, bus.wr_data, bus.wr_addr);
        end
        put(8'h05);
        checks++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== 8'd1) begin
            errors++;
            $display("FAIL m4_strobe_len got en=%b addr=%h want 0 01", bus.wr_en, bus.wr_addr);
        end
        for (int i = 6; i <= 8; i++) put(8'(i));
        checks++;
        if (bus.wr_en !== 1'b1 || bus.pack_done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL m4_final_timing got en=%b pd=%b busy=%b want 1 1 0", bus.wr_en, bus.pack_done, bus.busy);
        end
        idle(3);
        checks++;
        if (wq.size() !== 2) begin
            errors++;
            $display("FAIL m4_count got %0d want 2", wq.size());
        end else begin
            checks++;
            if (wq[0] !== '{d: 32'h04030201, a: 8'd0, pd: 1'b0, busy: 1'b1} ||
                wq[1] !== '{d: 32'h08070605, a: 8'd1, pd: 1'b1, busy: 1'b0}) begin
                errors++;
                $display("FAIL m4_words got %h@%h pd%b b%b, %h@%h pd%b b%b want 04030201@00 pd0 b1, 08070605@01 pd1 b0",
                         wq[0].d, wq[0].a, wq[0].pd, wq[0].busy, wq[1].d, wq[1].a, wq[1].pd, wq[1].busy);
            end
        end
        checks++;
        if (pd_cnt !== 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL m4_done got pd_cnt=%0d busy=%b want 1 0", pd_cnt, bus.busy);
        end
    endtask

    task automatic test_partial();
        clear_log();
        load(16'd6);
        for (int i = 1; i <= 6; i++) begin
            put(8'(i));
            idle(2);
        end
        idle(2);
        checks++;
        if (wq.size() !== 2) begin
            errors++;
            $display("FAIL part_count got %0d want 2", wq.size());
        end else begin
            checks++;
            if (wq[0].d !== 32'h04030201 || wq[0].a !== 8'd0 || wq[0].pd !== 1'b0 ||
                wq[1].d !== 32'h00000605 || wq[1].a !== 8'd1 || wq[1].pd !== 1'b1) begin
                errors++;
                $display("FAIL part_words got %h@%h pd%b, %h@%h pd%b want 04030201@00 pd0, 00000605@01 pd1",
                         wq[0].d, wq[0].a, wq[0].pd, wq[1].d, wq[1].a, wq[1].pd);
            end
        end
    endtask

    task automatic test_single_byte();
        clear_log();
        load(16'd1);
        put(8'hC3);
        idle(2);
        checks++;
        if (wq.size() !== 1 || wq[0] !== '{d: 32'h000000C3, a: 8'd0, pd: 1'b1, busy: 1'b0}) begin
            errors++;
            $display("FAIL single_word got n=%0d first=%h want 1 word 000000C3@00 pd1 busy0",
                     wq.size(), (wq.size() > 0) ? wq[0] : '0);
        end
    endtask

    task automatic test_zero_len();
        clear_log();
        load(16'd0);
        checks++;
        if (bus.pack_done !== 1'b1 || bus.busy !== 1'b0 || bus.wr_addr !== 8'd0) begin
            errors++;
            $display("FAIL zero_pd got pd=%b busy=%b addr=%h want 1 0 00", bus.pack_done, bus.busy, bus.wr_addr);
        end
        cyc();
        checks++;
        if (bus.pack_done !== 1'b0) begin errors++; $display("FAIL zero_pd_len got %b want 0", bus.pack_done); end
        idle(3);
        checks++;
        if (wq.size() !== 0 || busy_seen !== 1'b0 || pd_cnt !== 1) begin
            errors++;
            $display("FAIL zero_quiet got writes=%0d busy_seen=%b pd_cnt=%0d want 0 0 1", wq.size(), busy_seen, pd_cnt);
        end
    endtask

    task automatic test_overflow();
        clear_log();
        put(8'hAA);
        checks++;
        if (bus.ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus.ovf_err); end
        idle(2);
        checks++;
        if (bus.ovf_err !== 1'b1 || wq.size() !== 0) begin
            errors++;
            $display("FAIL ovf_sticky got ovf=%b writes=%0d want 1 0", bus.ovf_err, wq.size());
        end
        load(16'd4);
        checks++;
        if (bus.ovf_err !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear got ovf=%b busy=%b want 0 1", bus.ovf_err, bus.busy);
        end
        put(8'h11); put(8'h22); put(8'h33); put(8'h44);
        idle(2);
        checks++;
        if (wq.size() !== 1 || wq[0].d !== 32'h44332211 || wq[0].a !== 8'd0 || wq[0].pd !== 1'b1) begin
            errors++;
            $display("FAIL ovf_frame got n=%0d first=%h want 1 word 44332211@00 pd1",
                     wq.size(), (wq.size() > 0) ? wq[0] : '0);
        end
    endtask

    task automatic test_abort();
        clear_log();
        load(16'd8);
        put(8'hA1); put(8'hA2); put(8'hA3);
        bus.byte_vld  = 1'b1;
        bus.byte_data = 8'h99;
        load(16'd4);
        bus.byte_vld  = 1'b0;
        checks++;
        if (bus.ovf_err !== 1'b0 || bus.busy !== 1'b1 || wq.size() !== 0) begin
            errors++;
            $display("FAIL abort_state got ovf=%b busy=%b writes=%0d want 0 1 0", bus.ovf_err, bus.busy, wq.size());
        end
        put(8'h21); put(8'h22); put(8'h23); put(8'h24);
        idle(2);
        checks++;
        if (wq.size() !== 1 || wq[0].d !== 32'h24232221 || wq[0].a !== 8'd0 || wq[0].pd !== 1'b1 || pd_cnt !== 1) begin
            errors++;
            $display("FAIL abort_frame got n=%0d first=%h pd_cnt=%0d want 1 word 24232221@00 pd1, 1",
                     wq.size(), (wq.size() > 0) ? wq[0] : '0, pd_cnt);
        end
        checks++;
        if (bus.ovf_err !== 1'b0) begin errors++; $display("FAIL abort_ovf got %b want 0", bus.ovf_err); end
    endtask

    task automatic test_addr_wrap();
        clear_log();
        load(16'd1028);
        for (int i = 0; i < 1028; i++) put(8'(i));
        idle(2);
        checks++;
        if (wq.size() !== 257) begin
            errors++;
            $display("FAIL wrap_count got %0d want 257", wq.size());
        end else begin
            checks++;
            if (wq[255].d !== 32'hFFFEFDFC || wq[255].a !== 8'd255 || wq[255].pd !== 1'b0 ||
                wq[256].d !== 32'h03020100 || wq[256].a !== 8'd0 || wq[256].pd !== 1'b1) begin
                errors++;
                $display("FAIL wrap_words got %h@%h pd%b, %h@%h pd%b want FFFEFDFC@ff pd0, 03020100@00 pd1",
                         wq[255].d, wq[255].a, wq[255].pd, wq[256].d, wq[256].a, wq[256].pd);
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_log();
        load(16'd8);
        for (int i = 1; i <= 5; i++) put(8'(i));
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.wr_en, bus.wr_data, bus.wr_addr, bus.busy, bus.pack_done, bus.ovf_err} !== 44'd0) begin
            errors++;
            $display("FAIL rst_async got en=%b data=%h addr=%h busy=%b pd=%b ovf=%b want all 0",
                     bus.wr_en, bus.wr_data, bus.wr_addr, bus.busy, bus.pack_done, bus.ovf_err);
        end
        clear_log();
        idle(2);
        rst = 1'b0;
        cyc();
        put(8'h55); put(8'h56); put(8'h57);
        idle(3);
        checks++;
        if (wq.size() !== 0 || pd_cnt !== 0 || busy_seen !== 1'b0 || bus.ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL rst_after got writes=%0d pd_cnt=%0d busy_seen=%b ovf=%b want 0 0 0 1",
                     wq.size(), pd_cnt, busy_seen, bus.ovf_err);
        end
    endtask

    initial begin
        bus.load_rcv  = 1'b0;
        bus.wr_size   = 16'd0;
        bus.byte_vld  = 1'b0;
        bus.byte_data = 8'd0;
        test_reset();
        test_multiple4();
        test_partial();
        test_single_byte();
        test_zero_len();
        test_overflow();
        test_abort();
        test_addr_wrap();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
